// File: rtl/display_pkg.sv
// Shared types, constants and the double-dabble step used by the
// eight-digit signed decimal display converter.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_SHIFTS = 32;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    // One double-dabble iteration on {bcd[39:0], bin[31:0]}: add 3 to every
    // BCD nibble >= 5, then shift the whole register left by one.
    function automatic logic [71:0] dd_step(input logic [71:0] v);
        logic [71:0] t;
        t = v;
        for (int i = 0; i < 10; i++) begin
            if (t[32 + 4*i +: 4] >= 4'd5) begin
                t[32 + 4*i +: 4] = t[32 + 4*i +: 4] + 4'd3;
            end else begin
                t[32 + 4*i +: 4] = t[32 + 4*i +: 4];
            end
        end
        return {t[70:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern (gfedcba).
// Codes 10-15 are not valid BCD and show blank.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_bcd.sv
// Signed 32-bit word to eight-digit seven-segment display via a sequential
// double-dabble; the digits update together once per finished conversion.
module display_bcd
    import display_pkg::*;
#(
    parameter int BLANK_ZEROS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] valor,
    input  logic        load,
    output logic        busy,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        start_s;
    logic [31:0] start_val_s;
    logic        pend_clr_s;
    logic        pend_r;
    logic [31:0] pend_val_r;
    logic        busy_r;
    logic [4:0]  shift_cnt_r;
    logic [31:0] bin_r;
    logic [39:0] bcd_r;
    logic        sign_r;
    logic [6:0]  dec_s     [8];
    logic [6:0]  hex_nxt_s [8];
    logic [6:0]  hex_r     [8];
    logic        neg_s;
    logic        ovf_s;
    logic        lead_s;

    // Next state and conversion start selection
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        start_val_s = valor;
        pend_clr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_CONV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (shift_cnt_r == 5'(NUM_SHIFTS - 1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_DONE: begin
                // A fresh load is newer than anything pending, so it wins
                if (load) begin
                    start_s     = 1'b1;
                    pend_clr_s  = 1'b1;
                    state_nxt_s = ST_CONV;
                end else if (pend_r) begin
                    start_s     = 1'b1;
                    start_val_s = pend_val_r;
                    pend_clr_s  = 1'b1;
                    state_nxt_s = ST_CONV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand capture and double-dabble shifting
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_r       <= 32'd0;
            bcd_r       <= 40'd0;
            sign_r      <= 1'b0;
            shift_cnt_r <= 5'd0;
        end else if (start_s) begin
            // Two's-complement negate in 32 bits keeps 0x80000000 as its own magnitude
            bin_r       <= start_val_s[31] ? (~start_val_s + 32'd1) : start_val_s;
            sign_r      <= start_val_s[31];
            bcd_r       <= 40'd0;
            shift_cnt_r <= 5'd0;
        end else if (state_r == ST_CONV) begin
            {bcd_r, bin_r} <= dd_step({bcd_r, bin_r});
            shift_cnt_r    <= shift_cnt_r + 5'd1;
        end else begin
            shift_cnt_r <= shift_cnt_r;
        end
    end

    // One-deep pending buffer for loads arriving mid-conversion
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r     <= 1'b0;
            pend_val_r <= 32'd0;
        end else if (pend_clr_s) begin
            pend_r <= 1'b0;
        end else if (load && (state_r == ST_CONV)) begin
            pend_r     <= 1'b1;
            pend_val_r <= valor;
        end else begin
            pend_r <= pend_r;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_dec
            seg7_decoder u_dec (
                .digit (bcd_r[4*g +: 4]),
                .seg   (dec_s[g])
            );
        end
    endgenerate

    assign neg_s = sign_r && (bcd_r != 40'd0);
    assign ovf_s = neg_s ? (bcd_r[39:28] != 12'd0) : (bcd_r[39:32] != 8'd0);

    // Final display formatting: sign, leading-zero blanking and overflow
    always_comb begin
        lead_s = (BLANK_ZEROS != 0);
        for (int i = 0; i < 8; i++) begin
            hex_nxt_s[i] = SEG_BLANK;
        end
        if (ovf_s) begin
            hex_nxt_s[7] = SEG_E;
            hex_nxt_s[6] = SEG_R;
            hex_nxt_s[5] = SEG_R;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (neg_s && (i == 7)) begin
                    hex_nxt_s[i] = SEG_MINUS;
                end else if (lead_s && (i != 0) && (bcd_r[4*i +: 4] == 4'd0)) begin
                    hex_nxt_s[i] = SEG_BLANK;
                end else begin
                    lead_s       = 1'b0;
                    hex_nxt_s[i] = dec_s[i];
                end
            end
        end
    end

    // Output digits change only on the DONE edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                hex_r[i] <= SEG_BLANK;
            end
        end else if (state_r == ST_DONE) begin
            for (int i = 0; i < 8; i++) begin
                hex_r[i] <= hex_nxt_s[i];
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                hex_r[i] <= hex_r[i];
            end
        end
    end

    assign busy = busy_r;
    assign hex0 = hex_r[0];
    assign hex1 = hex_r[1];
    assign hex2 = hex_r[2];
    assign hex3 = hex_r[3];
    assign hex4 = hex_r[4];
    assign hex5 = hex_r[5];
    assign hex6 = hex_r[6];
    assign hex7 = hex_r[7];

endmodule

// File: tb/tb_display_bcd.sv
// Self-checking bench for display_bcd: directed and random words compared
// against an arithmetic decimal-display model, plus queueing and reset cases.
module tb_display_bcd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] valor = 32'd0;
    logic        load = 1'b0;
    logic        busy;
    logic [6:0]  hex [8];
    logic [55:0] act;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [55:0] ALL_BLANK = {8{7'h7F}};
    logic [55:0] exp_prev = ALL_BLANK;
    logic [6:0]  seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    display_bcd #(.BLANK_ZEROS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .valor (valor),
        .load  (load),
        .busy  (busy),
        .hex0  (hex[0]),
        .hex1  (hex[1]),
        .hex2  (hex[2]),
        .hex3  (hex[3]),
        .hex4  (hex[4]),
        .hex5  (hex[5]),
        .hex6  (hex[6]),
        .hex7  (hex[7])
    );

    always #5 clk = ~clk;

    assign act = {hex[7], hex[6], hex[5], hex[4], hex[3], hex[2], hex[1], hex[0]};

    // Expected display for a word, from its decimal value
    function automatic logic [55:0] model(input logic [31:0] w);
        logic [55:0] r;
        longint      v;
        longint      q;
        bit          neg;
        int          ndig;
        r    = ALL_BLANK;
        v    = longint'($signed(w));
        neg  = (v < 0);
        q    = neg ? -v : v;
        ndig = neg ? 7 : 8;
        if ((!neg && q > 64'd99999999) || (neg && q > 64'd9999999)) begin
            r[7*7 +: 7] = 7'h06;
            r[7*6 +: 7] = 7'h2F;
            r[7*5 +: 7] = 7'h2F;
        end else begin
            for (int i = 0; i < ndig; i++) begin
                if (i == 0 || q > 0) r[7*i +: 7] = seg_tbl[q % 10];
                q = q / 10;
            end
            if (neg) r[7*7 +: 7] = 7'h3F;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vec_cnt++;
        if (act !== ALL_BLANK) begin
            err_cnt++;
            $display("FAIL reset_hex: got %h want %h", act, ALL_BLANK);
        end
        exp_prev = ALL_BLANK;
    endtask

    // One isolated conversion, checked cycle by cycle for 33 cycles
    task automatic test_conv(input logic [31:0] w, input string name);
        logic [55:0] e;
        e     = model(w);
        valor = w;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        valor = $urandom;
        for (int c = 0; c <= 33; c++) begin
            vec_cnt++;
            if (busy !== (c < 33)) begin
                err_cnt++;
                $display("FAIL %s busy c=%0d: got %b want %b", name, c, busy, (c < 33));
            end
            vec_cnt++;
            if (act !== ((c < 33) ? exp_prev : e)) begin
                err_cnt++;
                $display("FAIL %s hex c=%0d: got %h want %h", name, c, act,
                         (c < 33) ? exp_prev : e);
            end
            if (c < 33) tick();
        end
        exp_prev = e;
    endtask

    task automatic test_directed();
        test_conv(32'd1234, "dec_1234");
        test_conv(32'hFFFFFFF9, "neg_7");
        test_conv(32'd0, "zero");
        test_conv(32'd100000000, "ovf_pos");
        test_conv(32'h80000000, "ovf_minint");
        test_conv(32'd99999999, "max_pos");
        test_conv(32'd0 - 32'd9999999, "max_neg");
        test_conv(32'd0 - 32'd10000000, "ovf_neg");
        test_conv(32'd10000000, "pos_8dig");
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       w = $urandom;
                1:       w = 32'($urandom_range(0, 120000000));
                2:       w = 32'd0 - 32'($urandom_range(0, 12000000));
                default: w = 32'($urandom_range(0, 999));
            endcase
            test_conv(w, "random");
        end
    endtask

    // Queued loads: 5 shown, 6 overwritten by 7, 7 shown, busy never drops
    task automatic test_back_to_back();
        logic [55:0] e5;
        logic [55:0] e7;
        logic [55:0] ew;
        e5    = model(32'd5);
        e7    = model(32'd7);
        valor = 32'd5;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        for (int c = 0; c <= 66; c++) begin
            ew = (c < 33) ? exp_prev : ((c < 66) ? e5 : e7);
            vec_cnt++;
            if (busy !== (c < 66)) begin
                err_cnt++;
                $display("FAIL b2b busy c=%0d: got %b want %b", c, busy, (c < 66));
            end
            vec_cnt++;
            if (act !== ew) begin
                err_cnt++;
                $display("FAIL b2b hex c=%0d: got %h want %h", c, act, ew);
            end
            if (c == 2)  begin valor = 32'd6; load = 1'b1; end
            else if (c == 9) begin valor = 32'd7; load = 1'b1; end
            else load = 1'b0;
            if (c < 66) tick();
        end
        load = 1'b0;
        exp_prev = e7;
    endtask

    // Load landing exactly on the DONE edge starts immediately
    task automatic test_load_at_done();
        logic [55:0] e8;
        logic [55:0] e9;
        logic [55:0] ew;
        e8    = model(32'd8);
        e9    = model(32'hFFFFFFF7);
        valor = 32'd8;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        for (int c = 0; c <= 66; c++) begin
            ew = (c < 33) ? exp_prev : ((c < 66) ? e8 : e9);
            vec_cnt++;
            if (busy !== (c < 66)) begin
                err_cnt++;
                $display("FAIL done_load busy c=%0d: got %b want %b", c, busy, (c < 66));
            end
            vec_cnt++;
            if (act !== ew) begin
                err_cnt++;
                $display("FAIL done_load hex c=%0d: got %h want %h", c, act, ew);
            end
            if (c == 32) begin valor = 32'hFFFFFFF7; load = 1'b1; end
            else load = 1'b0;
            if (c < 66) tick();
        end
        load = 1'b0;
        exp_prev = e9;
    endtask

    // Reset mid-conversion, and reset overriding a simultaneous load
    task automatic test_reset_mid();
        valor = 32'd42;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            vec_cnt++;
            if (busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL rst_mid busy c=%0d: got %b want 1", c, busy);
            end
            if (c == 9) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        exp_prev = ALL_BLANK;
        for (int c = 0; c < 40; c++) begin
            vec_cnt++;
            if (busy !== 1'b0 || act !== ALL_BLANK) begin
                err_cnt++;
                $display("FAIL rst_mid idle c=%0d: busy %b hex %h want 0 %h", c, busy, act, ALL_BLANK);
            end
            tick();
        end
        valor = 32'd3;
        load  = 1'b1;
        reset = 1'b1;
        tick();
        load  = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            vec_cnt++;
            if (busy !== 1'b0 || act !== ALL_BLANK) begin
                err_cnt++;
                $display("FAIL rst_load c=%0d: busy %b hex %h want 0 %h", c, busy, act, ALL_BLANK);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_load_at_done();
        test_conv(32'd123, "pre_reset");
        test_reset_mid();
        test_conv(32'd77, "after_reset");
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
